// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types and constants for the EX-stage divider.
//   div_op_e  : RV32M divide opcode encodings (DIV/DIVU/REM/REMU)
//   div_state_e : divider FSM states
//   helpers   : opcode decode for signedness and quotient/remainder select
package div_unit_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // DIV and REM are the signed forms (bit 0 clear).
  function automatic logic is_signed_op(input div_op_e op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder (bit 1 set).
  function automatic logic is_rem_op(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage <-> divider connection.
//   master : EX stage side (drives request, opcode, operands, hazard/flush)
//   slave  : divider side (drives result, stall and done)
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            div_req;
  logic [1:0]      div_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            load_hazard;
  logic            flush;
  logic [XLEN-1:0] res;
  logic            div_stall;
  logic            div_done;

  modport master (
    output div_req, div_op, op_a, op_b, load_hazard, flush,
    input  res, div_stall, div_done
  );

  modport slave (
    input  div_req, div_op, op_a, op_b, load_hazard, flush,
    output res, div_stall, div_done
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in/quo_in : current partial remainder and quotient shift register
//   divisor       : magnitude of the divisor
//   rem_out/quo_out : values after shifting {rem,quo} left by one and
//                     conditionally subtracting the divisor
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The shifted remainder is below 2*divisor, so bit XLEN of the
  // difference is set exactly when the subtraction would underflow.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[XLEN]) begin
      rem_out = shifted[XLEN-1:0];
    end else begin
      rem_out = diff[XLEN-1:0];
    end
    quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in EX.
//   CLK   : clock
//   nrst  : synchronous active-low reset
//   bus   : div_unit_if.slave
//           in : div_req, div_op, op_a, op_b, load_hazard, flush
//           out: res (valid in DONE), div_stall (comb), div_done
// Optional build macro: DIV_RESULT_CACHE_EN adds a one-entry result cache
// keyed on op_a, op_b and signedness.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic      CLK,
  input  logic      nrst,
  div_unit_if.slave bus
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN-1:0] res_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            is_rem_q;
  logic            done_q;

  div_op_e         op_in;
  logic            sgn_in;
  logic            rem_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] spec_quo;
  logic [XLEN-1:0] spec_rem;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;
  logic            hit;

  assign bus.res       = res_q;
  assign bus.div_done  = done_q;
  assign bus.div_stall = bus.div_req & (state != DIV_DONE);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  // Request decode, used only while IDLE.
  always_comb begin
    op_in    = div_op_e'(bus.div_op);
    sgn_in   = is_signed_op(op_in);
    rem_in   = is_rem_op(op_in);
    a_neg    = sgn_in & bus.op_a[XLEN-1];
    b_neg    = sgn_in & bus.op_b[XLEN-1];
    a_abs    = a_neg ? -bus.op_a : bus.op_a;
    b_abs    = b_neg ? -bus.op_b : bus.op_b;
    div_zero = (bus.op_b == '0);
    ovf      = sgn_in & (bus.op_a == INT_MIN) & (bus.op_b == '1);
    spec_quo = div_zero ? '1 : INT_MIN;
    spec_rem = div_zero ? bus.op_a : '0;
  end

  // Sign fix-up of the final step's outputs, registered on entry to DONE.
  always_comb begin
    fin_quo = neg_quo_q ? -quo_step : quo_step;
    fin_rem = neg_rem_q ? -rem_step : rem_step;
  end

`ifdef DIV_RESULT_CACHE_EN
  logic            c_valid;
  logic [XLEN-1:0] c_a;
  logic [XLEN-1:0] c_b;
  logic            c_sgn;
  logic [XLEN-1:0] c_quo;
  logic [XLEN-1:0] c_rem;
  logic [XLEN-1:0] lat_a;
  logic [XLEN-1:0] lat_b;
  logic            lat_sgn;

  assign hit = c_valid & (c_a == bus.op_a) & (c_b == bus.op_b) & (c_sgn == sgn_in);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      c_valid   <= 1'b0;
      c_a       <= '0;
      c_b       <= '0;
      c_sgn     <= 1'b0;
      c_quo     <= '0;
      c_rem     <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_sgn   <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.div_req && !bus.flush) begin
            is_rem_q <= rem_in;
            if (hit) begin
`ifdef DIV_RESULT_CACHE_EN
              res_q  <= rem_in ? c_rem : c_quo;
`endif
              state  <= DIV_DONE;
              done_q <= 1'b1;
            end else if (div_zero || ovf) begin
              res_q  <= rem_in ? spec_rem : spec_quo;
              state  <= DIV_DONE;
              done_q <= 1'b1;
`ifdef DIV_RESULT_CACHE_EN
              c_valid <= 1'b1;
              c_a     <= bus.op_a;
              c_b     <= bus.op_b;
              c_sgn   <= sgn_in;
              c_quo   <= spec_quo;
              c_rem   <= spec_rem;
`endif
            end else begin
              rem_q     <= '0;
              quo_q     <= a_abs;
              dvsr_q    <= b_abs;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt       <= CNT_W'(XLEN);
              state     <= DIV_CALC;
`ifdef DIV_RESULT_CACHE_EN
              lat_a     <= bus.op_a;
              lat_b     <= bus.op_b;
              lat_sgn   <= sgn_in;
`endif
            end
          end
        end

        DIV_CALC: begin
          // A dropped request without flush is an abort, same as a flush.
          if (bus.flush || !bus.div_req) begin
            state <= DIV_IDLE;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              res_q  <= is_rem_q ? fin_rem : fin_quo;
              state  <= DIV_DONE;
              done_q <= 1'b1;
`ifdef DIV_RESULT_CACHE_EN
              c_valid <= 1'b1;
              c_a     <= lat_a;
              c_b     <= lat_b;
              c_sgn   <= lat_sgn;
              c_quo   <= fin_quo;
              c_rem   <= fin_rem;
`endif
            end
          end
        end

        DIV_DONE: begin
          if (bus.flush || !bus.load_hazard) begin
            state  <= DIV_IDLE;
            done_q <= 1'b0;
          end
        end

        default: begin
          state  <= DIV_IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
